aurora_traffic_gen_chk: RTL and testbench

//  Per-channel AXIS traffic generator and loopback checker for the multi-channel Aurora 64b66b wrapper.

---
 rtl/aurora_traffic_gen_chk.sv | 195 +++++++++++++++++++
 tb/tb_aurora_traffic_gen_chk.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aurora_traffic_gen_chk.sv
// Per-channel AXIS traffic generator and loopback checker for the Aurora 64b66b wrapper.
// Every byte of a beat carries (packet index + beat index) mod 256, so the RX side can check without a side channel.
//
// state   | meaning
// IDLE    | channel not running; waits for start with ch_en set
// WAIT_UP | run armed; waits for channel_up before driving tvalid
// SEND    | driving beats; leaves on last packet, pending stop or link drop
module aurora_traffic_gen_chk #(
  parameter int CH_CNT   = 2,
  parameter int BYTE_CNT = 16,
  parameter int LEN_W    = 16,
  parameter int CNT_W    = 32
) (
  input  logic                         user_clk,
  input  logic                         user_rst_n,
  input  logic                         start,
  input  logic                         stop,
  input  logic [CH_CNT-1:0]            ch_en,
  input  logic [LEN_W-1:0]             pack_len,
  input  logic [CNT_W-1:0]             pack_num,
  input  logic [CH_CNT-1:0]            channel_up,
  output logic [CH_CNT*8*BYTE_CNT-1:0] tx_tdata,
  output logic [CH_CNT*BYTE_CNT-1:0]   tx_tkeep,
  output logic [CH_CNT-1:0]            tx_tvalid,
  output logic [CH_CNT-1:0]            tx_tlast,
  input  logic [CH_CNT-1:0]            tx_tready,
  input  logic [CH_CNT*8*BYTE_CNT-1:0] rx_tdata,
  input  logic [CH_CNT*BYTE_CNT-1:0]   rx_tkeep,
  input  logic [CH_CNT-1:0]            rx_tvalid,
  input  logic [CH_CNT-1:0]            rx_tlast,
  output logic [CH_CNT-1:0]            busy,
  output logic [CH_CNT*CNT_W-1:0]      tx_pkt_cnt,
  output logic [CH_CNT*CNT_W-1:0]      rx_pkt_cnt,
  output logic [CH_CNT*CNT_W-1:0]      rx_err_cnt
);

  localparam int DW = 8 * BYTE_CNT;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_UP = 2'd1,
    ST_SEND    = 2'd2
  } gen_state_e;

  for (genvar ch = 0; ch < CH_CNT; ch++) begin : g_ch
    gen_state_e       state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] beat_q, beat_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [7:0]       pkt_q, pkt_d;
    logic             stop_q, stop_d;

    logic [LEN_W-1:0] exp_beat_q, exp_beat_d;
    logic [7:0]       exp_pkt_q, exp_pkt_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic             launch;
    logic             send;
    logic             tx_last;
    logic [7:0]       tx_byte;
    logic [CNT_W-1:0] tx_cnt_inc;
    logic             stop_now;
    logic [7:0]       exp_byte;
    logic             exp_last;
    logic             rx_bad;

    assign launch     = start && ch_en[ch] && (state_q == ST_IDLE);
    assign send       = (state_q == ST_SEND);
    assign tx_last    = (beat_q == len_q - LEN_W'(1));
    assign tx_byte    = pkt_q + beat_q[7:0];
    assign tx_cnt_inc = (&tx_cnt_q) ? tx_cnt_q : tx_cnt_q + CNT_W'(1);
    assign stop_now   = stop || stop_q;

    always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      num_d    = num_q;
      beat_d   = beat_q;
      pkt_d    = pkt_q;
      tx_cnt_d = tx_cnt_q;
      stop_d   = stop_q;
      case (state_q)
        ST_IDLE: begin
          if (launch) begin
            state_d  = ST_WAIT_UP;
            len_d    = (pack_len == '0) ? LEN_W'(1) : pack_len;
            num_d    = pack_num;
            beat_d   = '0;
            pkt_d    = '0;
            tx_cnt_d = '0;
            stop_d   = 1'b0;
          end
        end
        ST_WAIT_UP: begin
          if (stop_now) begin
            state_d = ST_IDLE;
            stop_d  = 1'b0;
          end else if (channel_up[ch]) begin
            state_d = ST_SEND;
          end
        end
        ST_SEND: begin
          if (stop) stop_d = 1'b1;
          // A link drop discards the beat on the bus; the packet is replayed from beat 0.
          if (!channel_up[ch]) begin
            state_d = ST_WAIT_UP;
            beat_d  = '0;
          end else if (tx_tready[ch]) begin
            if (tx_last) begin
              tx_cnt_d = tx_cnt_inc;
              pkt_d    = pkt_q + 8'd1;
              beat_d   = '0;
              if (((num_q != '0) && (tx_cnt_inc == num_q)) || stop_now) begin
                state_d = ST_IDLE;
                stop_d  = 1'b0;
              end
            end else begin
              beat_d = beat_q + LEN_W'(1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    assign exp_byte = exp_pkt_q + exp_beat_q[7:0];
    assign exp_last = (exp_beat_q == len_q - LEN_W'(1));
    assign rx_bad   = (rx_tdata[ch*DW +: DW] != {BYTE_CNT{exp_byte}})
                   || (rx_tkeep[ch*BYTE_CNT +: BYTE_CNT] != {BYTE_CNT{1'b1}})
                   || (rx_tlast[ch] != exp_last);

    // Checker resyncs on every rx_tlast, whatever the beat count said.
    always_comb begin
      exp_beat_d = exp_beat_q;
      exp_pkt_d  = exp_pkt_q;
      rx_cnt_d   = rx_cnt_q;
      err_cnt_d  = err_cnt_q;
      if (launch) begin
        exp_beat_d = '0;
        exp_pkt_d  = '0;
        rx_cnt_d   = '0;
        err_cnt_d  = '0;
      end else if (rx_tvalid[ch]) begin
        if (rx_bad && !(&err_cnt_q)) err_cnt_d = err_cnt_q + CNT_W'(1);
        if (rx_tlast[ch]) begin
          exp_beat_d = '0;
          exp_pkt_d  = exp_pkt_q + 8'd1;
          if (!(&rx_cnt_q)) rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end else begin
          exp_beat_d = exp_beat_q + LEN_W'(1);
        end
      end
    end

    always_ff @(posedge user_clk) begin
      if (!user_rst_n) begin
        state_q    <= ST_IDLE;
        len_q      <= LEN_W'(1);
        num_q      <= '0;
        beat_q     <= '0;
        pkt_q      <= '0;
        tx_cnt_q   <= '0;
        stop_q     <= 1'b0;
        exp_beat_q <= '0;
        exp_pkt_q  <= '0;
        rx_cnt_q   <= '0;
        err_cnt_q  <= '0;
      end else begin
        state_q    <= state_d;
        len_q      <= len_d;
        num_q      <= num_d;
        beat_q     <= beat_d;
        pkt_q      <= pkt_d;
        tx_cnt_q   <= tx_cnt_d;
        stop_q     <= stop_d;
        exp_beat_q <= exp_beat_d;
        exp_pkt_q  <= exp_pkt_d;
        rx_cnt_q   <= rx_cnt_d;
        err_cnt_q  <= err_cnt_d;
      end
    end

    assign tx_tvalid[ch]                      = send;
    assign tx_tdata[ch*DW +: DW]              = send ? {BYTE_CNT{tx_byte}} : '0;
    assign tx_tkeep[ch*BYTE_CNT +: BYTE_CNT]  = send ? {BYTE_CNT{1'b1}} : '0;
    assign tx_tlast[ch]                       = send && tx_last;
    assign busy[ch]                           = (state_q != ST_IDLE);
    assign tx_pkt_cnt[ch*CNT_W +: CNT_W]      = tx_cnt_q;
    assign rx_pkt_cnt[ch*CNT_W +: CNT_W]      = rx_cnt_q;
    assign rx_err_cnt[ch*CNT_W +: CNT_W]      = err_cnt_q;
  end

endmodule

// File: tb/tb_aurora_traffic_gen_chk.sv
// Directed bench for aurora_traffic_gen_chk: registered TX->RX loopback, a TX reference model
// and per-scenario tasks with hand-computed expectations.
module tb_aurora_traffic_gen_chk;
  logic         clk = 1'b0;
  logic         user_rst_n;
  logic         start, stop;
  logic [1:0]   ch_en;
  logic [15:0]  pack_len;
  logic [31:0]  pack_num;
  logic [1:0]   channel_up;
  logic [255:0] tx_tdata;
  logic [31:0]  tx_tkeep;
  logic [1:0]   tx_tvalid, tx_tlast, tx_tready;
  logic [255:0] rx_tdata;
  logic [31:0]  rx_tkeep;
  logic [1:0]   rx_tvalid, rx_tlast;
  logic [1:0]   busy;
  logic [63:0]  tx_pkt_cnt, rx_pkt_cnt, rx_err_cnt;

  int n_chk = 0;
  int n_pass = 0;

  logic rdy_rand = 1'b0;
  logic corrupt_en = 1'b0;
  logic mon_clr = 1'b0;
  int   mon_len = 1;
  int   mon_pkt[2], mon_beat[2], mon_beats[2], mon_bad[2], mon_unstable[2];
  logic         prev_hold[2];
  logic [127:0] prev_d[2];
  logic         prev_l[2];
  int   lb_pkt[2], lb_beat[2];

  aurora_traffic_gen_chk dut (
    .user_clk(clk), .user_rst_n(user_rst_n), .start(start), .stop(stop),
    .ch_en(ch_en), .pack_len(pack_len), .pack_num(pack_num), .channel_up(channel_up),
    .tx_tdata(tx_tdata), .tx_tkeep(tx_tkeep), .tx_tvalid(tx_tvalid), .tx_tlast(tx_tlast),
    .tx_tready(tx_tready), .rx_tdata(rx_tdata), .rx_tkeep(rx_tkeep), .rx_tvalid(rx_tvalid),
    .rx_tlast(rx_tlast), .busy(busy), .tx_pkt_cnt(tx_pkt_cnt), .rx_pkt_cnt(rx_pkt_cnt),
    .rx_err_cnt(rx_err_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    #1;
    tx_tready = rdy_rand ? 2'($urandom_range(0, 3)) : 2'b11;
  end

  // Loopback: one register stage, optional corruption of byte 0 of beat 3 of packet 1 on channel 1.
  always @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (!user_rst_n || mon_clr) begin
        rx_tvalid[c] <= 1'b0;
        rx_tlast[c] <= 1'b0;
        rx_tdata[c*128 +: 128] <= '0;
        rx_tkeep[c*16 +: 16] <= '0;
        lb_pkt[c] <= 0;
        lb_beat[c] <= 0;
      end else if (tx_tvalid[c] && tx_tready[c] && channel_up[c]) begin
        rx_tvalid[c] <= 1'b1;
        rx_tlast[c] <= tx_tlast[c];
        rx_tkeep[c*16 +: 16] <= tx_tkeep[c*16 +: 16];
        rx_tdata[c*128 +: 128] <= tx_tdata[c*128 +: 128] ^
          ((corrupt_en && c == 1 && lb_pkt[c] == 1 && lb_beat[c] == 3) ? 128'hFF : 128'h0);
        lb_pkt[c] <= tx_tlast[c] ? lb_pkt[c] + 1 : lb_pkt[c];
        lb_beat[c] <= tx_tlast[c] ? 0 : lb_beat[c] + 1;
      end else begin
        rx_tvalid[c] <= 1'b0;
      end
    end
  end

  // TX reference model, sampled just before each rising edge.
  always @(negedge clk) begin
    logic [127:0] lane;
    logic [7:0]   eb;
    logic         el;
    #3;
    for (int c = 0; c < 2; c++) begin
      if (mon_clr) begin
        mon_pkt[c] = 0; mon_beat[c] = 0; mon_beats[c] = 0; mon_bad[c] = 0;
        mon_unstable[c] = 0; prev_hold[c] = 1'b0; prev_d[c] = '0; prev_l[c] = 1'b0;
      end else begin
        lane = tx_tdata[c*128 +: 128];
        if (prev_hold[c] && (!tx_tvalid[c] || lane !== prev_d[c] || tx_tlast[c] !== prev_l[c]))
          mon_unstable[c]++;
        if (!channel_up[c]) begin
          mon_beat[c] = 0;
        end else if (tx_tvalid[c] && tx_tready[c]) begin
          mon_beats[c]++;
          eb = 8'(mon_pkt[c] + mon_beat[c]);
          el = (mon_beat[c] == mon_len - 1);
          if (lane !== {16{eb}} || tx_tkeep[c*16 +: 16] !== 16'hFFFF || tx_tlast[c] !== el)
            mon_bad[c]++;
          if (el) begin
            mon_pkt[c]++;
            mon_beat[c] = 0;
          end else begin
            mon_beat[c]++;
          end
        end
        prev_hold[c] = tx_tvalid[c] && !tx_tready[c] && channel_up[c];
        prev_d[c] = lane;
        prev_l[c] = tx_tlast[c];
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic kick(input logic [1:0] en, input logic [15:0] len, input logic [31:0] num,
                      input int mlen);
    mon_len = mlen;
    mon_clr = 1'b1;
    step();
    mon_clr = 1'b0;
    ch_en = en;
    pack_len = len;
    pack_num = num;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    user_rst_n = 1'b0;
    start = 1'b0; stop = 1'b0; ch_en = 2'b00; pack_len = 16'd0; pack_num = 32'd0;
    channel_up = 2'b11;
    repeat (4) step();
    n_chk++; if (busy !== 2'b00) $display("FAIL reset_busy: got %b want 00", busy); else n_pass++;
    n_chk++; if (tx_tvalid !== 2'b00) $display("FAIL reset_tvalid: got %b want 00", tx_tvalid); else n_pass++;
    n_chk++; if (tx_tkeep !== 32'h0) $display("FAIL reset_tkeep: got %h want 0", tx_tkeep); else n_pass++;
    n_chk++; if ({tx_pkt_cnt, rx_pkt_cnt, rx_err_cnt} !== 192'h0)
      $display("FAIL reset_counters: got %h want 0", {tx_pkt_cnt, rx_pkt_cnt, rx_err_cnt}); else n_pass++;
    user_rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    kick(2'b11, 16'd16, 32'd4, 16);
    n_chk++; if (busy !== 2'b11) $display("FAIL basic_busy_T1: got %b want 11", busy); else n_pass++;
    n_chk++; if (tx_tvalid !== 2'b00) $display("FAIL basic_tvalid_T1: got %b want 00", tx_tvalid); else n_pass++;
    step();
    n_chk++; if (tx_tvalid !== 2'b11) $display("FAIL basic_tvalid_T2: got %b want 11", tx_tvalid); else n_pass++;
    n_chk++; if (tx_tdata[127:0] !== 128'h0) $display("FAIL basic_first_data: got %h want 0", tx_tdata[127:0]); else n_pass++;
    for (int i = 0; i < 300 && busy !== 2'b00; i++) step();
    n_chk++; if (busy !== 2'b00) $display("FAIL basic_busy_fall: got %b want 00", busy); else n_pass++;
    repeat (3) step();
    n_chk++; if (mon_beats[0] != 64 || mon_beats[1] != 64)
      $display("FAIL basic_beats: got %0d/%0d want 64/64", mon_beats[0], mon_beats[1]); else n_pass++;
    n_chk++; if (mon_bad[0] != 0 || mon_bad[1] != 0)
      $display("FAIL basic_tx_content: got %0d/%0d bad beats want 0", mon_bad[0], mon_bad[1]); else n_pass++;
    n_chk++; if (tx_pkt_cnt !== {32'd4, 32'd4}) $display("FAIL basic_tx_cnt: got %h want 4/4", tx_pkt_cnt); else n_pass++;
    n_chk++; if (rx_pkt_cnt !== {32'd4, 32'd4}) $display("FAIL basic_rx_cnt: got %h want 4/4", rx_pkt_cnt); else n_pass++;
    n_chk++; if (rx_err_cnt !== 64'h0) $display("FAIL basic_err_cnt: got %h want 0", rx_err_cnt); else n_pass++;
  endtask

  task automatic test_backpressure();
    rdy_rand = 1'b1;
    kick(2'b11, 16'd16, 32'd4, 16);
    for (int i = 0; i < 1500 && busy !== 2'b00; i++) step();
    rdy_rand = 1'b0;
    n_chk++; if (busy !== 2'b00) $display("FAIL bp_busy_fall: got %b want 00", busy); else n_pass++;
    repeat (3) step();
    n_chk++; if (mon_unstable[0] != 0 || mon_unstable[1] != 0)
      $display("FAIL bp_stable: got %0d/%0d unstable cycles want 0", mon_unstable[0], mon_unstable[1]); else n_pass++;
    n_chk++; if (mon_bad[0] != 0 || mon_bad[1] != 0 || mon_beats[0] != 64 || mon_beats[1] != 64)
      $display("FAIL bp_tx_content: got bad %0d/%0d beats %0d/%0d want 0/0 64/64",
               mon_bad[0], mon_bad[1], mon_beats[0], mon_beats[1]); else n_pass++;
    n_chk++; if ({tx_pkt_cnt, rx_pkt_cnt, rx_err_cnt} !== {32'd4, 32'd4, 32'd4, 32'd4, 64'h0})
      $display("FAIL bp_counts: got tx %h rx %h err %h want 4/4 4/4 0", tx_pkt_cnt, rx_pkt_cnt, rx_err_cnt); else n_pass++;
  endtask

  task automatic test_error_inject();
    corrupt_en = 1'b1;
    kick(2'b11, 16'd16, 32'd4, 16);
    for (int i = 0; i < 300 && busy !== 2'b00; i++) step();
    repeat (3) step();
    corrupt_en = 1'b0;
    n_chk++; if (rx_err_cnt[63:32] !== 32'd1) $display("FAIL err_ch1: got %0d want 1", rx_err_cnt[63:32]); else n_pass++;
    n_chk++; if (rx_err_cnt[31:0] !== 32'd0) $display("FAIL err_ch0: got %0d want 0", rx_err_cnt[31:0]); else n_pass++;
    n_chk++; if (rx_pkt_cnt !== {32'd4, 32'd4}) $display("FAIL err_rx_cnt: got %h want 4/4", rx_pkt_cnt); else n_pass++;
  endtask

  task automatic test_len_zero();
    kick(2'b11, 16'd0, 32'd3, 1);
    step();
    n_chk++; if (tx_tlast !== 2'b11) $display("FAIL len0_tlast: got %b want 11", tx_tlast); else n_pass++;
    step();
    n_chk++; if (tx_tdata[127:0] !== {16{8'h01}}) $display("FAIL len0_second_byte: got %h want 01s", tx_tdata[127:0]); else n_pass++;
    for (int i = 0; i < 50 && busy !== 2'b00; i++) step();
    repeat (3) step();
    n_chk++; if (mon_beats[0] != 3 || mon_bad[0] != 0 || mon_beats[1] != 3 || mon_bad[1] != 0)
      $display("FAIL len0_beats: got beats %0d/%0d bad %0d/%0d want 3/3 0/0",
               mon_beats[0], mon_beats[1], mon_bad[0], mon_bad[1]); else n_pass++;
    n_chk++; if ({tx_pkt_cnt, rx_pkt_cnt, rx_err_cnt} !== {32'd3, 32'd3, 32'd3, 32'd3, 64'h0})
      $display("FAIL len0_counts: got tx %h rx %h err %h want 3/3 3/3 0", tx_pkt_cnt, rx_pkt_cnt, rx_err_cnt); else n_pass++;
  endtask

  task automatic test_stop();
    int i;
    kick(2'b01, 16'd8, 32'd0, 8);
    for (i = 0; i < 100 && !(mon_pkt[0] == 2 && mon_beat[0] == 5); i++) step();
    n_chk++; if (i >= 100) $display("FAIL stop_reach_beat: got pkt %0d beat %0d want 2/5", mon_pkt[0], mon_beat[0]); else n_pass++;
    stop = 1'b1;
    step();
    stop = 1'b0;
    n_chk++; if (busy[0] !== 1'b1) $display("FAIL stop_still_busy: got %b want 1", busy[0]); else n_pass++;
    for (i = 0; i < 50 && busy[0] !== 1'b0; i++) step();
    n_chk++; if (busy[0] !== 1'b0) $display("FAIL stop_busy_fall: got %b want 0", busy[0]); else n_pass++;
    n_chk++; if (tx_pkt_cnt[31:0] !== 32'd3 || mon_beats[0] != 24)
      $display("FAIL stop_count: got %0d pkts %0d beats want 3 24", tx_pkt_cnt[31:0], mon_beats[0]); else n_pass++;
  endtask

  task automatic test_link_drop();
    int i;
    kick(2'b01, 16'd16, 32'd1, 16);
    for (i = 0; i < 50 && !(mon_pkt[0] == 0 && mon_beat[0] == 5); i++) step();
    channel_up[0] = 1'b0;
    step();
    n_chk++; if (tx_tvalid[0] !== 1'b0) $display("FAIL drop_tvalid: got %b want 0", tx_tvalid[0]); else n_pass++;
    n_chk++; if (busy[0] !== 1'b1) $display("FAIL drop_busy: got %b want 1", busy[0]); else n_pass++;
    repeat (9) step();
    channel_up[0] = 1'b1;
    for (i = 0; i < 5 && tx_tvalid[0] !== 1'b1; i++) step();
    n_chk++; if (tx_tvalid[0] !== 1'b1 || tx_tdata[127:0] !== 128'h0 || tx_tlast[0] !== 1'b0)
      $display("FAIL drop_resend_beat0: got v=%b d=%h l=%b want 1 0 0", tx_tvalid[0], tx_tdata[127:0], tx_tlast[0]); else n_pass++;
    for (i = 0; i < 50 && busy[0] !== 1'b0; i++) step();
    n_chk++; if (tx_pkt_cnt[31:0] !== 32'd1 || mon_beats[0] != 21 || mon_bad[0] != 0)
      $display("FAIL drop_totals: got pkts %0d beats %0d bad %0d want 1 21 0",
               tx_pkt_cnt[31:0], mon_beats[0], mon_bad[0]); else n_pass++;
  endtask

  task automatic test_reset_mid();
    kick(2'b11, 16'd2, 32'd0, 2);
    repeat (8) step();
    n_chk++; if (tx_pkt_cnt[31:0] === 32'd0) $display("FAIL rstmid_running: got %0d want nonzero", tx_pkt_cnt[31:0]); else n_pass++;
    user_rst_n = 1'b0;
    step();
    n_chk++; if (busy !== 2'b00 || tx_tvalid !== 2'b00 || tx_tlast !== 2'b00)
      $display("FAIL rstmid_ctrl: got busy %b valid %b last %b want 0", busy, tx_tvalid, tx_tlast); else n_pass++;
    n_chk++; if (tx_tdata !== 256'h0 || tx_tkeep !== 32'h0)
      $display("FAIL rstmid_data: got %h %h want 0", tx_tdata, tx_tkeep); else n_pass++;
    n_chk++; if ({tx_pkt_cnt, rx_pkt_cnt, rx_err_cnt} !== 192'h0)
      $display("FAIL rstmid_counters: got %h want 0", {tx_pkt_cnt, rx_pkt_cnt, rx_err_cnt}); else n_pass++;
    user_rst_n = 1'b1;
    repeat (3) step();
    n_chk++; if (busy !== 2'b00) $display("FAIL rstmid_stays_idle: got %b want 00", busy); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_error_inject();
    test_len_zero();
    test_stop();
    test_link_drop();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
